mem_stage_lsu: RTL and testbench

Memory-stage load/store unit of the RISC-V pipeline. It sits between the EX/MEM register and the MEM/WB register, and produces the `load_data`, `rd_field`, `pc`, `is_call` and `writeback` values that MEM/WB latches. It runs a request/ready handshake to data memory, with byte enables for stores and alignment plus sign/zero extension for loads. It stalls upstream while an access is outstanding and reports misaligned, unsupported or timed-out accesses.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_load_align.sv | 26 ++
 rtl/mem_stage_lsu.sv | 187 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and access-legality helpers for the
// memory-stage load/store unit.
package lsu_pkg;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Unsigned variants only exist for loads.
  function automatic logic is_legal_f3(input logic is_load,
                                       input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return is_load;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/halfword from a memory word and applies
// sign or zero extension according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    data    = rdata;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {24'h000000, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {16'h0000, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: accepts one instruction at a time from EX/MEM, runs the
// data-memory handshake, and presents registered results to MEM/WB.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic [31:0] pc_in,
  input  logic        is_call_in,
  input  logic        writeback_in,
  output logic        in_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] load_data,
  output logic [4:0]  rd_field,
  output logic [31:0] pc,
  output logic        is_call,
  output logic        writeback,
  output logic        mem_fault
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic [CW-1:0] timeout_cnt;
  logic [2:0]    f3_q;
  logic [1:0]    addr_lo_q;
  logic          is_load_q;
  logic [4:0]    rd_q;
  logic [31:0]   pc_q;
  logic          call_q;
  logic          wb_q;

  logic        mem_op;
  logic        access_fault;
  logic        accept;
  logic        start_req;
  logic        mem_done;
  logic        timed_out;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] aligned_data;

  assign mem_op       = is_load | is_store;
  assign access_fault = mem_op & (~is_legal_f3(is_load, funct3) |
                                  is_misaligned(funct3, addr[1:0]));
  assign accept       = (state_q == IDLE) & in_valid;
  assign start_req    = accept & mem_op & ~access_fault;
  assign mem_done     = (state_q == REQ) & dmem_ready;
  // Ready in the same cycle as the last allowed wait still completes.
  assign timed_out    = (state_q == REQ) & ~dmem_ready & (timeout_cnt == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == IDLE);
    case (state_q)
      IDLE:    if (start_req) state_d = REQ;
      REQ:     if (mem_done || timed_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = store_data;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be_next    = 4'b0001 << addr[1:0];
          wdata_next = {4{store_data[7:0]}};
        end
        2'b01: begin
          be_next    = 4'b0011 << addr[1:0];
          wdata_next = {2{store_data[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = store_data;
        end
      endcase
    end
  end

  lsu_load_align u_load_align (
    .funct3 (f3_q),
    .addr   (addr_lo_q),
    .rdata  (dmem_rdata),
    .data   (aligned_data)
  );

  // Strobes and writeback default low every cycle so MEM/WB sees bubbles;
  // sideband outputs only change when a result is presented.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      timeout_cnt <= '0;
      f3_q        <= 3'b000;
      addr_lo_q   <= 2'b00;
      is_load_q   <= 1'b0;
      rd_q        <= 5'd0;
      pc_q        <= 32'd0;
      call_q      <= 1'b0;
      wb_q        <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'd0;
      dmem_wdata  <= 32'd0;
      dmem_be     <= 4'b0000;
      out_valid   <= 1'b0;
      mem_fault   <= 1'b0;
      load_data   <= 32'd0;
      rd_field    <= 5'd0;
      pc          <= 32'd0;
      is_call     <= 1'b0;
      writeback   <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= 1'b0;
      mem_fault <= 1'b0;
      writeback <= 1'b0;

      if (accept) begin
        f3_q      <= funct3;
        addr_lo_q <= addr[1:0];
        is_load_q <= is_load;
        rd_q      <= rd_in;
        pc_q      <= pc_in;
        call_q    <= is_call_in;
        wb_q      <= writeback_in;
        if (start_req) begin
          dmem_req    <= 1'b1;
          dmem_we     <= is_store;
          dmem_addr   <= {addr[31:2], 2'b00};
          dmem_be     <= be_next;
          dmem_wdata  <= wdata_next;
          timeout_cnt <= '0;
        end else begin
          out_valid <= 1'b1;
          mem_fault <= access_fault;
          writeback <= writeback_in & ~access_fault;
          load_data <= 32'd0;
          rd_field  <= rd_in;
          pc        <= pc_in;
          is_call   <= is_call_in;
        end
      end

      if (mem_done) begin
        dmem_req  <= 1'b0;
        out_valid <= 1'b1;
        writeback <= wb_q;
        load_data <= is_load_q ? aligned_data : 32'd0;
        rd_field  <= rd_q;
        pc        <= pc_q;
        is_call   <= call_q;
      end else if (timed_out) begin
        dmem_req  <= 1'b0;
        out_valid <= 1'b1;
        mem_fault <= 1'b1;
        load_data <= 32'd0;
        rd_field  <= rd_q;
        pc        <= pc_q;
        is_call   <= call_q;
      end else if (state_q == REQ) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed cases plus randomized traffic
// checked against a byte-level reference model.
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, pc_in;
  logic [4:0]  rd_in;
  logic        is_call_in, writeback_in;
  logic        in_ready, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic [31:0] load_data, pc;
  logic [4:0]  rd_field;
  logic        is_call, writeback, mem_fault;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        call;
    logic        wb;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
    .rd_in(rd_in), .pc_in(pc_in), .is_call_in(is_call_in),
    .writeback_in(writeback_in), .in_ready(in_ready), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .load_data(load_data), .rd_field(rd_field),
    .pc(pc), .is_call(is_call), .writeback(writeback), .mem_fault(mem_fault)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Access size in bytes, signedness and legality from the ISA encoding.
  function automatic exp_t predict(input logic ld, input logic st,
                                   input logic [2:0] f3, input logic [31:0] a,
                                   input logic [4:0] rd, input logic [31:0] p,
                                   input logic call, input logic wb,
                                   input int delay, input logic [31:0] rdata,
                                   output logic issues_req, output int size);
    exp_t   e;
    logic   legal = 1'b1;
    logic   sgn   = 1'b0;
    longint v;
    size = 4;
    e.data = 32'd0; e.rd = rd; e.pc = p; e.call = call; e.wb = wb; e.fault = 1'b0;
    issues_req = 1'b0;
    if (!(ld || st)) return e;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 4;
      3'd4: begin size = 1; legal = ld; end
      3'd5: begin size = 2; legal = ld; end
      default: legal = 1'b0;
    endcase
    if ((a % size) != 0) legal = 1'b0;
    if (!legal || delay >= TO) begin
      e.fault = 1'b1;
      e.wb    = 1'b0;
      issues_req = legal;
      return e;
    end
    issues_req = 1'b1;
    if (ld) begin
      v = rdata;
      v = (v >> (8 * (a % 4))) & ((64'd1 << (8 * size)) - 1);
      if (sgn && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
      e.data = v[31:0];
    end
    return e;
  endfunction

  task automatic apply_stimulus(input logic ld, input logic st,
                                input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [4:0] rd,
                                input logic [31:0] p, input logic call,
                                input logic wb, input int delay,
                                input logic [31:0] rdata);
    int          guard = 0;
    int          size;
    int          o;
    logic        issues_req;
    logic [3:0]  be_exp;
    logic [31:0] wd_exp;
    logic [31:0] sd_v;
    exp_t        e;
    while (!in_ready && guard < 100) begin
      @(posedge clock); #1;
      guard++;
    end
    if (!in_ready) check_output("in_ready_wait", 32'(in_ready), 32'd1);
    is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    rd_in = rd; pc_in = p; is_call_in = call; writeback_in = wb;
    in_valid   = 1'b1;
    dmem_ready = 1'($urandom_range(0, 1));
    e = predict(ld, st, f3, a, rd, p, call, wb, delay, rdata, issues_req, size);
    sb_q.push_back(e);
    @(posedge clock); #1;
    in_valid   = 1'b0;
    dmem_ready = 1'b0;
    if (!issues_req) begin
      check_output("no_req", 32'(dmem_req), 32'd0);
      check_output("direct_valid", 32'(out_valid), 32'd1);
      return;
    end
    o = int'(a % 4);
    sd_v = sd;
    be_exp = 4'b1111;
    wd_exp = sd;
    if (st) begin
      for (int i = 0; i < 4; i++) begin
        be_exp[i] = (i >= o) && (i < o + size);
        wd_exp[8*i +: 8] = sd_v[8*(i % size) +: 8];
      end
    end
    check_output("req_rise", 32'(dmem_req), 32'd1);
    check_output("req_we", 32'(dmem_we), 32'(st));
    check_output("req_addr", dmem_addr, a & 32'hFFFF_FFFC);
    check_output("req_be", 32'(dmem_be), 32'(be_exp));
    if (st) check_output("req_wdata", dmem_wdata, wd_exp);
    for (int j = 0; j < 64; j++) begin
      if (j == delay) begin
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
        @(posedge clock); #1;
        dmem_ready = 1'b0;
        dmem_rdata = $urandom;
        check_output("req_drop", 32'(dmem_req), 32'd0);
        check_output("mem_valid", 32'(out_valid), 32'd1);
        break;
      end
      @(posedge clock); #1;
      if (j + 1 == TO) begin
        check_output("to_req_drop", 32'(dmem_req), 32'd0);
        check_output("to_fault", 32'(mem_fault), 32'd1);
        check_output("to_in_ready", 32'(in_ready), 32'd1);
        break;
      end
      check_output("req_hold", 32'(dmem_req), 32'd1);
      check_output("addr_hold", dmem_addr, a & 32'hFFFF_FFFC);
      check_output("be_hold", 32'(dmem_be), 32'(be_exp));
    end
  endtask

  task automatic reset_mid_access();
    while (!in_ready) begin @(posedge clock); #1; end
    is_load = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h300;
    rd_in = 5'd9; pc_in = 32'h4000; is_call_in = 1'b0; writeback_in = 1'b1;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    dmem_ready = 1'b0;
    check_output("rst_req_up", 32'(dmem_req), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_output("rst_req_drop", 32'(dmem_req), 32'd0);
    check_output("rst_no_valid", 32'(out_valid), 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (4) @(posedge clock);
    #1;
  endtask

  // Monitor: every presented result must match the oldest prediction.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check_output("unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_output("mem_fault", 32'(mem_fault), 32'(e.fault));
          check_output("writeback", 32'(writeback), 32'(e.wb));
          check_output("rd_field", 32'(rd_field), 32'(e.rd));
          check_output("pc", pc, e.pc);
          check_output("is_call", 32'(is_call), 32'(e.call));
          if (!e.fault) check_output("load_data", load_data, e.data);
        end
      end else begin
        check_output("bubble_wb", 32'(writeback), 32'd0);
        check_output("bubble_fault", 32'(mem_fault), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] a;
    reset = 1'b1; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'd0; addr = 32'd0; store_data = 32'd0; rd_in = 5'd0;
    pc_in = 32'd0; is_call_in = 1'b0; writeback_in = 1'b0;
    dmem_ready = 1'b0; dmem_rdata = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    check_output("rst_dmem_req", 32'(dmem_req), 32'd0);
    check_output("rst_dmem_be", 32'(dmem_be), 32'd0);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_load_data", load_data, 32'd0);
    check_output("rst_writeback", 32'(writeback), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    apply_stimulus(1, 0, F3_W,  32'h100, 32'h0, 5'd5, 32'h1000, 0, 1, 3, 32'hDEADBEEF);
    apply_stimulus(1, 0, F3_B,  32'h103, 32'h0, 5'd6, 32'h1004, 0, 1, 0, 32'h80AABBCC);
    apply_stimulus(1, 0, F3_BU, 32'h103, 32'h0, 5'd7, 32'h1008, 0, 1, 1, 32'h80AABBCC);
    apply_stimulus(1, 0, F3_H,  32'h102, 32'h0, 5'd8, 32'h100C, 0, 1, 2, 32'h80AABBCC);
    apply_stimulus(0, 1, F3_B,  32'h201, 32'h1234565A, 5'd0, 32'h1010, 0, 0, 1, 32'h0);
    apply_stimulus(0, 1, F3_H,  32'h202, 32'h0000BEEF, 5'd0, 32'h1014, 0, 0, 0, 32'h0);
    apply_stimulus(1, 0, F3_W,  32'h102, 32'h0, 5'd3, 32'h1018, 0, 1, 0, 32'h0);
    apply_stimulus(1, 0, 3'b011, 32'h100, 32'h0, 5'd4, 32'h101C, 1, 1, 0, 32'h0);
    apply_stimulus(1, 0, F3_W,  32'h104, 32'h0, 5'd10, 32'h1020, 0, 1, 10, 32'h0);
    apply_stimulus(0, 0, 3'b000, 32'h0, 32'h0, 5'd11, 32'h1024, 1, 1, 0, 32'h0);
    reset_mid_access();
    apply_stimulus(1, 0, F3_W,  32'h300, 32'h0, 5'd9, 32'h1028, 0, 1, 1, 32'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 2))
        0:       begin ld = 1'b0; st = 1'b0; f3 = 3'($urandom_range(0, 7)); end
        1:       begin ld = 1'b1; st = 1'b0; f3 = 3'($urandom_range(0, 7)); end
        default: begin ld = 1'b0; st = 1'b1; f3 = 3'($urandom_range(0, 3)); end
      endcase
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      apply_stimulus(ld, st, f3, a, $urandom, 5'($urandom), $urandom,
                     1'($urandom), 1'($urandom), $urandom_range(0, 5), $urandom);
    end

    repeat (4) @(posedge clock);
    #1;
    check_output("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
